uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one `async_transmitter` byte port among NUM_REQ packet-oriented requesters, e.g. the SHA256 result reporter, the status/ack responder and the debug echo.
- Round-robin arbitration at packet granularity: once granted, a requester keeps the transmitter until its byte flagged `last` has been fully shifted out.
- Sequences `TxD_start` from the transmitter's `TxD_busy`, so no requester ever drives the transmitter directly.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width; fixed to match the transmitter.
- TIMEOUT_CYC, 50_000, idle cycles tolerated mid-packet; used only with UART_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  NUM_REQ*DATA_W  byte of requester i at [i*DATA_W +: DATA_W].
- req_last  in  NUM_REQ  byte is the last of its packet.
- req_ready  out  NUM_REQ  byte accepted when valid&ready.
- tx_start  out  1  to TxD_start.
- tx_data  out  DATA_W  to TxD_data.
- tx_busy  in  1  from TxD_busy.
- grant_valid  out  1  a packet owns the transmitter.
- grant_id  out  clog2(NUM_REQ)  current or last owner.
- timeout_err  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE.
  - Outputs: tx_start=0, tx_data=0, req_ready=0, grant_valid=0, grant_id=0, timeout_err=0.
  - rr_ptr=NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, FETCH, START, WAIT_BUSY, WAIT_IDLE.
- IDLE:
  - Arbitrate only when |req_valid and tx_busy==0. Reset mid-byte leaves the transmitter running, so IDLE must not start a byte while tx_busy is high.
  - Winner is the first asserted index searching rr_ptr+1, rr_ptr+2, … modulo NUM_REQ.
  - Register grant_id=winner, grant_valid=1, then go to FETCH.
- FETCH:
  - req_ready[grant_id]=1 (combinational from state and grant_id); all other ready bits are 0.
  - On req_valid[grant_id]: latch tx_data and last_q, then go to START.
  - Otherwise stay in FETCH; requests from other requesters are ignored.
- START: tx_start=1 for exactly one cycle (registered), then go to WAIT_BUSY.
- WAIT_BUSY: wait for tx_busy==1, then go to WAIT_IDLE. tx_data is held stable.
- WAIT_IDLE: wait for tx_busy==0.
  - If last_q: rr_ptr<=grant_id, grant_valid<=0, go to IDLE. grant_id keeps its value.
  - Else: go to FETCH.
- Latency: a request in IDLE at cycle n gives FETCH and ready at n+1, transfer at n+1, tx_start at n+2.
- Throughput: one byte per transmitter frame plus 3 cycles of overhead.
- Requester-side rules:
  - A single-byte packet is simply last=1 on the first byte.
  - Deasserting req_valid mid-packet stalls in FETCH.
  - req_last is sampled only on a transfer.
- Rotation: simultaneous requests are served one packet each in ascending order from rr_ptr+1. A requester is never granted twice in a row while another is pending.
- At most one req_ready bit is high in any cycle.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs only in FETCH and clears on every transfer.
  - When it reaches TIMEOUT_CYC-1 with no transfer: pulse timeout_err, set rr_ptr<=grant_id, grant_valid<=0, go to IDLE.
  - The abandoned packet is truncated; there is no rollback.
- Undefined:
  - No counter is built; the grant is held indefinitely.
  - timeout_err is tied to 0.

Decomposition:
- Shared package uart_arb_pkg holds:
  - the state enum;
  - IDW=clog2(NUM_REQ) helper;
  - default NUM_REQ and TIMEOUT_CYC constants.
- One natural sub-module, rr_pick: combinational round-robin selector.
  - Inputs: req vector and rr_ptr.
  - Outputs: winner index and any_req.
  - Reusable by future shared-resource controllers, e.g. the hash core job dispatcher.

Test Plan (transmitter stub: busy rises the cycle after start, stays high 10 cycles):
- Single request: req0 sends 0x55 with last=1 → tx_start one cycle at n+2, tx_data=0x55, grant released after busy falls, grant_id=0.
- Packet lock: req1 sends 3 bytes 0xA1,0xA2,0xA3 while req2 holds valid from cycle 2 → three tx_start pulses for req1's bytes, then req2 is granted; no req2 ready during req1's packet.
- Round-robin: req0, req1 and req3 all valid with 1-byte packets after reset → grant order 0,1,3,0.
- Reset mid-packet: rst_n low during WAIT_IDLE → all outputs at reset values immediately; after release, no tx_start until tx_busy has fallen.
- Stall: granted req2 drops valid for 20 cycles mid-packet → stays in FETCH with req_ready[2]=1, no tx_start, resumes on the next valid.
- Timeout (macro defined, TIMEOUT_CYC=16): granted requester idle 16 cycles in FETCH → timeout_err pulses once, grant_valid=0, next pending requester granted. Without the macro the grant is held and timeout_err stays 0.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and constants for the UART transmit arbiter
package uart_arb_pkg;

   localparam int NUM_REQ_DEF     = 4;
   localparam int DATA_W_DEF      = 8;
   localparam int TIMEOUT_CYC_DEF = 50_000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_START,
      ST_WAIT_BUSY,
      ST_WAIT_IDLE
   } arb_state_e;

   function automatic int idw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin selector
// Winner is the first asserted request after ptr_i, wrapping modulo N.
module rr_pick
   import uart_arb_pkg::*;
#(
   parameter int N   = NUM_REQ_DEF,
   parameter int IDW = idw(N)
) (
   input  logic [N-1:0]   req_i,
   input  logic [IDW-1:0] ptr_i,
   output logic [IDW-1:0] winner_o,
   output logic           any_o
);

   logic           found;
   logic [IDW-1:0] idx;

   always_comb begin
      winner_o = '0;
      found    = 1'b0;
      idx      = '0;
      for (int k = 1; k <= N; k++) begin
         idx = IDW'((int'(ptr_i) + k) % N);
         if (!found && req_i[idx]) begin
            winner_o = idx;
            found    = 1'b1;
         end
      end
   end

   assign any_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin sharing of one UART transmitter
// Optional mid-packet idle timeout is built only when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ     = NUM_REQ_DEF,
   parameter int DATA_W      = DATA_W_DEF,
`ifdef UART_ARB_TIMEOUT_EN
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
`endif
   localparam int IDW        = idw(NUM_REQ)
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]        req_last_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   output logic                      tx_start_o,
   output logic [DATA_W-1:0]         tx_data_o,
   input  logic                      tx_busy_i,
   output logic                      grant_valid_o,
   output logic [IDW-1:0]            grant_id_o,
   output logic                      timeout_err_o
);

   arb_state_e        state_q, state_d;
   logic [IDW-1:0]    grant_id_q, grant_id_d;
   logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
   logic              grant_valid_q, grant_valid_d;
   logic [DATA_W-1:0] tx_data_q, tx_data_d;
   logic              last_q, last_d;
   logic              tx_start_q;
   logic [IDW-1:0]    winner;
   logic              any_req;
   logic              xfer;
   logic              timeout_hit;

   rr_pick #(.N(NUM_REQ), .IDW(IDW)) u_rr_pick (
      .req_i    (req_valid_i),
      .ptr_i    (rr_ptr_q),
      .winner_o (winner),
      .any_o    (any_req)
   );

   assign xfer = (state_q == ST_FETCH) && req_valid_i[grant_id_q];

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_err_q;

   assign timeout_hit = (state_q == ST_FETCH) && !xfer && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
   assign cnt_d       = (state_q != ST_FETCH || xfer || timeout_hit) ? '0 : cnt_q + CNT_W'(1);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q         <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         timeout_err_q <= timeout_hit;
      end
   end

   assign timeout_err_o = timeout_err_q;
`else
   assign timeout_hit   = 1'b0;
   assign timeout_err_o = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= ST_IDLE;
         grant_id_q    <= '0;
         rr_ptr_q      <= IDW'(NUM_REQ - 1);
         grant_valid_q <= 1'b0;
         tx_data_q     <= '0;
         last_q        <= 1'b0;
         tx_start_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_id_q    <= grant_id_d;
         rr_ptr_q      <= rr_ptr_d;
         grant_valid_q <= grant_valid_d;
         tx_data_q     <= tx_data_d;
         last_q        <= last_d;
         tx_start_q    <= (state_d == ST_START);
      end
   end

   always_comb begin
      state_d       = state_q;
      grant_id_d    = grant_id_q;
      rr_ptr_d      = rr_ptr_q;
      grant_valid_d = grant_valid_q;
      tx_data_d     = tx_data_q;
      last_d        = last_q;
      case (state_q)
         // A reset can land mid-byte, so never start while the shifter is still busy.
         ST_IDLE: begin
            if (any_req && !tx_busy_i) begin
               state_d       = ST_FETCH;
               grant_id_d    = winner;
               grant_valid_d = 1'b1;
            end
         end
         ST_FETCH: begin
            if (xfer) begin
               tx_data_d = req_data_i[int'(grant_id_q)*DATA_W +: DATA_W];
               last_d    = req_last_i[grant_id_q];
               state_d   = ST_START;
            end else if (timeout_hit) begin
               rr_ptr_d      = grant_id_q;
               grant_valid_d = 1'b0;
               state_d       = ST_IDLE;
            end
         end
         ST_START: state_d = ST_WAIT_BUSY;
         ST_WAIT_BUSY: begin
            if (tx_busy_i) state_d = ST_WAIT_IDLE;
         end
         ST_WAIT_IDLE: begin
            if (!tx_busy_i) begin
               if (last_q) begin
                  rr_ptr_d      = grant_id_q;
                  grant_valid_d = 1'b0;
                  state_d       = ST_IDLE;
               end else begin
                  state_d = ST_FETCH;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready_o = '0;
      if (state_q == ST_FETCH) req_ready_o[grant_id_q] = 1'b1;
   end

   assign tx_start_o    = tx_start_q;
   assign tx_data_o     = tx_data_q;
   assign grant_valid_o = grant_valid_q;
   assign grant_id_o    = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter with a transmitter stub
module tb_uart_tx_arbiter;

   localparam int NR  = 4;
   localparam int DW  = 8;
   localparam int IDW = 2;
`ifdef UART_ARB_TIMEOUT_EN
   localparam int STALL_CYC = 10;
`else
   localparam int STALL_CYC = 20;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [NR-1:0]    req_valid = '0;
   logic [NR*DW-1:0] req_data = '0;
   logic [NR-1:0]    req_last = '0;
   logic [NR-1:0]    req_ready;
   logic             tx_start;
   logic [DW-1:0]    tx_data;
   logic             tx_busy;
   logic             grant_valid;
   logic [IDW-1:0]   grant_id;
   logic             timeout_err;

   int busy_cnt = 0;
   int n_checks = 0;
   int n_fail   = 0;
   int m_ptr    = NR - 1;
   int grant_log[$];
   logic [8:0] sq [NR][$];
   logic [8:0] exq[NR][$];

   always #5 clk = ~clk;

   // Transmitter stub: busy rises the cycle after start and stays high 10 cycles.
   always @(posedge clk) begin
      if (tx_start) busy_cnt <= 10;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end
   assign tx_busy = (busy_cnt != 0);

   uart_tx_arbiter #(
      .NUM_REQ     (NR),
`ifdef UART_ARB_TIMEOUT_EN
      .TIMEOUT_CYC (16),
`endif
      .DATA_W      (DW)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .req_valid_i   (req_valid),
      .req_data_i    (req_data),
      .req_last_i    (req_last),
      .req_ready_o   (req_ready),
      .tx_start_o    (tx_start),
      .tx_data_o     (tx_data),
      .tx_busy_i     (tx_busy),
      .grant_valid_o (grant_valid),
      .grant_id_o    (grant_id),
      .timeout_err_o (timeout_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int rr_model(input logic [NR-1:0] v, input int ptr);
      for (int k = 1; k <= NR; k++) begin
         int idx;
         idx = (ptr + k) % NR;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic do_reset();
      int g;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      rst_n     = 1'b0;
      repeat (2) @(posedge clk);
      g = 0;
      while (tx_busy && g < 50) begin
         @(posedge clk);
         g++;
      end
      #1 rst_n = 1'b1;
      m_ptr = NR - 1;
      for (int i = 0; i < NR; i++) begin
         sq[i].delete();
         exq[i].delete();
      end
      grant_log.delete();
   endtask

   task automatic add_pkt(input int id, input int len);
      logic [8:0] e;
      for (int b = 0; b < len; b++) begin
         e = {(b == len - 1) ? 1'b1 : 1'b0, 8'($urandom_range(0, 255))};
         sq[id].push_back(e);
         exq[id].push_back(e);
      end
   endtask

   task automatic add_byte(input int id, input logic [7:0] d, input logic l);
      sq[id].push_back({l, d});
      exq[id].push_back({l, d});
   endtask

   // Queue-driven requesters checked against a transaction-level round-robin model.
   task automatic run_traffic(input int max_cyc, input int pvalid);
      logic [NR-1:0] hs, prev_valid;
      logic          prev_gv, pkt_done, all_empty;
      logic [8:0]    e;
      int            cyc, win, m_owner;
      prev_valid = '0;
      prev_gv    = grant_valid;
      pkt_done   = 1'b0;
      m_owner    = 0;
      cyc        = 0;
      forever begin
         @(negedge clk);
         check("ready_onehot", ($countones(req_ready) <= 1), 1);
         if (!prev_gv && grant_valid) begin
            win = rr_model(prev_valid, m_ptr);
            check("rr_winner", grant_id, win);
            m_owner = (win < 0) ? 0 : win;
            grant_log.push_back(win);
         end
         if (req_ready != '0) check("ready_owner", req_ready, 1 << m_owner);
         if (tx_start) begin
            if (exq[m_owner].size() == 0) begin
               check("tx_extra", 1, 0);
            end else begin
               e = exq[m_owner].pop_front();
               check("tx_data", tx_data, e[7:0]);
               pkt_done = e[8];
            end
         end
         if (prev_gv && !grant_valid) begin
            check("release_after_last", pkt_done, 1);
            pkt_done = 1'b0;
            m_ptr    = m_owner;
         end
         hs         = req_valid & req_ready;
         prev_gv    = grant_valid;
         prev_valid = req_valid;
         all_empty  = 1'b1;
         for (int i = 0; i < NR; i++) if (exq[i].size() != 0) all_empty = 1'b0;
         if (all_empty && !grant_valid) break;
         cyc++;
         if (cyc >= max_cyc) begin
            check("traffic_timeout", 0, 1);
            break;
         end
         tick();
         for (int i = 0; i < NR; i++) begin
            if (hs[i]) void'(sq[i].pop_front());
            if (sq[i].size() > 0 && $urandom_range(0, 99) < pvalid) begin
               e = sq[i][0];
               req_valid[i]           = 1'b1;
               req_data[i*DW +: DW]   = e[7:0];
               req_last[i]            = e[8];
            end else begin
               req_valid[i] = 1'b0;
            end
         end
      end
      req_valid = '0;
   endtask

   int cyc, cnt, pidx;
   logic ok;

   initial begin
      #200_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tx_start", tx_start, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_ready", req_ready, 0);
      check("rst_gv", grant_valid, 0);
      check("rst_gid", grant_id, 0);
      check("rst_timeout", timeout_err, 0);
      do_reset();

      // Single one-byte packet, exact latency and release timing
      tick();
      req_valid[0] = 1'b1; req_data[7:0] = 8'h55; req_last[0] = 1'b1;
      @(negedge clk);
      check("single_n_gv", grant_valid, 0);
      check("single_n_ready", req_ready, 0);
      tick();
      @(negedge clk);
      check("single_n1_ready", req_ready, 4'b0001);
      check("single_n1_gv", grant_valid, 1);
      check("single_n1_start", tx_start, 0);
      tick();
      req_valid = '0;
      @(negedge clk);
      check("single_n2_start", tx_start, 1);
      check("single_n2_data", tx_data, 8'h55);
      tick();
      @(negedge clk);
      check("single_n3_start", tx_start, 0);
      cyc = 3;
      while (grant_valid && cyc < 100) begin
         tick();
         @(negedge clk);
         cyc++;
      end
      check("single_release_cyc", cyc, 14);
      check("single_gid", grant_id, 0);

      // Packet lock: req1 three bytes while req2 waits
      do_reset();
      add_byte(1, 8'hA1, 1'b0); add_byte(1, 8'hA2, 1'b0); add_byte(1, 8'hA3, 1'b1);
      add_byte(2, 8'hB7, 1'b1);
      run_traffic(400, 100);
      check("lock_ngrants", grant_log.size(), 2);
      if (grant_log.size() == 2) begin
         check("lock_first", grant_log[0], 1);
         check("lock_second", grant_log[1], 2);
      end

      // Round robin: 0,1,3,0
      do_reset();
      add_pkt(0, 1); add_pkt(0, 1); add_pkt(1, 1); add_pkt(3, 1);
      run_traffic(400, 100);
      check("rr_ngrants", grant_log.size(), 4);
      if (grant_log.size() == 4) begin
         check("rr_order0", grant_log[0], 0);
         check("rr_order1", grant_log[1], 1);
         check("rr_order2", grant_log[2], 3);
         check("rr_order3", grant_log[3], 0);
      end

      // Randomized traffic
      do_reset();
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < NR; i++)
            repeat ($urandom_range(1, 3)) add_pkt(i, $urandom_range(1, 4));
         run_traffic(5000, (r == 0) ? 80 : 60);
      end

      // Reset during WAIT_IDLE
      do_reset();
      tick();
      req_valid = 4'b0011; req_data[7:0] = 8'h3C; req_last = 4'b0010; req_data[15:8] = 8'h4D;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
         if (!tx_start) tick();
      end while (!tx_start && cnt < 20);
      check("rstmid_first_start", tx_start, 1);
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      check("rstmid_tx_start", tx_start, 0);
      check("rstmid_tx_data", tx_data, 0);
      check("rstmid_ready", req_ready, 0);
      check("rstmid_gv", grant_valid, 0);
      check("rstmid_gid", grant_id, 0);
      check("rstmid_timeout", timeout_err, 0);
      tick();
      rst_n = 1'b1;
      ok = 1'b1;
      cnt = 0;
      @(negedge clk);
      while (tx_busy && cnt < 30) begin
         if (tx_start || grant_valid) ok = 1'b0;
         tick();
         @(negedge clk);
         cnt++;
      end
      check("rstmid_hold_while_busy", ok, 1);
      cnt = 0;
      while (!tx_start && cnt < 10) begin
         tick();
         @(negedge clk);
         cnt++;
      end
      check("rstmid_restart", tx_start, 1);
      check("rstmid_restart_gid", grant_id, 0);

      // Stall mid-packet
      do_reset();
      tick();
      req_valid[2] = 1'b1; req_data[23:16] = 8'hC1; req_last[2] = 1'b0;
      cnt = 0;
      @(negedge clk);
      while (!(req_ready[2] && req_valid[2]) && cnt < 10) begin
         tick(); @(negedge clk); cnt++;
      end
      tick();
      req_valid[2] = 1'b0;
      cnt = 0;
      @(negedge clk);
      while (!req_ready[2] && cnt < 40) begin
         tick(); @(negedge clk); cnt++;
      end
      ok = 1'b1;
      pidx = 0;
      for (int s = 0; s < STALL_CYC; s++) begin
         if (req_ready != 4'b0100) ok = 1'b0;
         pidx += int'(tx_start);
         tick();
         @(negedge clk);
      end
      check("stall_ready_held", ok, 1);
      check("stall_no_start", pidx, 0);
      check("stall_gv", grant_valid, 1);
      tick();
      req_valid[2] = 1'b1; req_data[23:16] = 8'hC2; req_last[2] = 1'b1;
      cnt = 0;
      @(negedge clk);
      while (!tx_start && cnt < 6) begin
         tick(); @(negedge clk); cnt++;
         if (cnt == 1) req_valid[2] = 1'b0;
      end
      check("stall_resume_start", tx_start, 1);
      check("stall_resume_data", tx_data, 8'hC2);

      // Owner idle in FETCH with another requester pending
      do_reset();
      tick();
      req_valid = 4'b0011; req_data[7:0] = 8'h11; req_data[15:8] = 8'h22; req_last = 4'b0010;
      tick();
      req_valid[0] = 1'b0;
      cnt  = 0;
      pidx = -1;
      for (int s = 0; s < 30; s++) begin
         @(negedge clk);
         if (timeout_err) begin
            cnt++;
            pidx = s;
            check("timeout_release_gv", grant_valid, 0);
         end
         tick();
      end
`ifdef UART_ARB_TIMEOUT_EN
      check("timeout_pulses", cnt, 1);
      check("timeout_pulse_cyc", pidx, 16);
      check("timeout_next_gid", grant_id, 1);
`else
      check("notimeout_pulses", cnt, 0);
      check("notimeout_gv", grant_valid, 1);
      check("notimeout_gid", grant_id, 0);
      check("notimeout_ready", req_ready, 4'b0001);
`endif
      req_valid = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
